// File: rtl/fc_layer_seq.sv
// Fully-connected layer sequencer: walks NUM_OUT neurons, fetching each
// weight row and bias, presenting registered operands to an external
// combinational dot-product unit, and streaming registered sums downstream
// over a valid/ready handshake.
module fc_layer_seq #(
  parameter int BIT_WIDTH  = 32,
  parameter int OUT_WIDTH  = 64,
  parameter int N_IN       = 120,
  parameter int NUM_OUT    = 84,
  parameter int ADDR_WIDTH = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [BIT_WIDTH*N_IN-1:0] in_vec,
  output logic                      busy,
  output logic                      done,
  output logic                      w_rd_en,
  output logic [ADDR_WIDTH-1:0]     w_addr,
  input  logic [BIT_WIDTH*N_IN-1:0] w_rd_data,
  input  logic [BIT_WIDTH-1:0]      b_rd_data,
  output logic [BIT_WIDTH*N_IN-1:0] dp_in,
  output logic [BIT_WIDTH*N_IN-1:0] dp_weights,
  output logic [BIT_WIDTH-1:0]      dp_bias,
  input  logic [OUT_WIDTH-1:0]      dp_sum,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [OUT_WIDTH-1:0]      res_data,
  output logic [ADDR_WIDTH-1:0]     res_idx
);

  localparam int VEC_W = BIT_WIDTH * N_IN;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_OUT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_WAIT,
    S_COMPUTE,
    S_OUTPUT,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] idx_q, idx_d;
  logic [VEC_W-1:0]      dp_in_q, dp_in_d;
  logic [VEC_W-1:0]      dp_w_q, dp_w_d;
  logic [BIT_WIDTH-1:0]  dp_b_q, dp_b_d;
  logic [OUT_WIDTH-1:0]  res_data_q, res_data_d;
  logic [ADDR_WIDTH-1:0] res_idx_q, res_idx_d;

  // State and neuron index register; reset aborts any pass in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  // Operand and result registers; a pending result is dropped on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dp_in_q    <= '0;
      dp_w_q     <= '0;
      dp_b_q     <= '0;
      res_data_q <= '0;
      res_idx_q  <= '0;
    end else begin
      dp_in_q    <= dp_in_d;
      dp_w_q     <= dp_w_d;
      dp_b_q     <= dp_b_d;
      res_data_q <= res_data_d;
      res_idx_q  <= res_idx_d;
    end
  end

  // Next-state, register-load and strobe decode for the neuron sequence.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    dp_in_d    = dp_in_q;
    dp_w_d     = dp_w_q;
    dp_b_d     = dp_b_q;
    res_data_d = res_data_q;
    res_idx_d  = res_idx_q;
    busy       = 1'b0;
    done       = 1'b0;
    w_rd_en    = 1'b0;
    w_addr     = '0;
    res_valid  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          dp_in_d = in_vec;
          idx_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        busy    = 1'b1;
        w_rd_en = 1'b1;
        w_addr  = idx_q;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // Memory data is only trusted in the cycle after the read strobe.
        busy    = 1'b1;
        dp_w_d  = w_rd_data;
        dp_b_d  = b_rd_data;
        state_d = S_COMPUTE;
      end
      S_COMPUTE: begin
        busy       = 1'b1;
        res_data_d = dp_sum;
        res_idx_d  = idx_q;
        state_d    = S_OUTPUT;
      end
      S_OUTPUT: begin
        busy      = 1'b1;
        res_valid = 1'b1;
        if (res_ready) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + ADDR_WIDTH'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign dp_in      = dp_in_q;
  assign dp_weights = dp_w_q;
  assign dp_bias    = dp_b_q;
  assign res_data   = res_data_q;
  assign res_idx    = res_idx_q;

endmodule

// File: tb/tb_fc_layer_seq.sv
// Bench for fc_layer_seq: two instances (NUM_OUT=3 and NUM_OUT=1), each with
// a weight memory that returns garbage outside the read-response cycle and a
// combinational dot unit, checked against a scoreboard of expected results.
module tb_fc_layer_seq;

  localparam int BW = 32;
  localparam int OW = 64;
  localparam int NI = 120;
  localparam int AW = 7;
  localparam int VW = BW * NI;

  typedef struct {
    logic [OW-1:0] data;
    logic [AW-1:0] idx;
    int            cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  logic          start3, busy3, done3, w_en3, valid3, ready3;
  logic [VW-1:0] in_vec3, w_data3, dp_in3, dp_w3;
  logic [BW-1:0] b_data3, dp_b3;
  logic [AW-1:0] w_addr3, res_idx3;
  logic [OW-1:0] dp_sum3, res_data3;

  logic          start1, busy1, done1, w_en1, valid1, ready1;
  logic [VW-1:0] in_vec1, w_data1, dp_in1, dp_w1;
  logic [BW-1:0] b_data1, dp_b1;
  logic [AW-1:0] w_addr1, res_idx1;
  logic [OW-1:0] dp_sum1, res_data1;

  fc_layer_seq #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .N_IN(NI), .NUM_OUT(3), .ADDR_WIDTH(AW)) dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .in_vec(in_vec3), .busy(busy3), .done(done3),
    .w_rd_en(w_en3), .w_addr(w_addr3), .w_rd_data(w_data3), .b_rd_data(b_data3),
    .dp_in(dp_in3), .dp_weights(dp_w3), .dp_bias(dp_b3), .dp_sum(dp_sum3),
    .res_valid(valid3), .res_ready(ready3), .res_data(res_data3), .res_idx(res_idx3)
  );

  fc_layer_seq #(.BIT_WIDTH(BW), .OUT_WIDTH(OW), .N_IN(NI), .NUM_OUT(1), .ADDR_WIDTH(AW)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .in_vec(in_vec1), .busy(busy1), .done(done1),
    .w_rd_en(w_en1), .w_addr(w_addr1), .w_rd_data(w_data1), .b_rd_data(b_data1),
    .dp_in(dp_in1), .dp_weights(dp_w1), .dp_bias(dp_b1), .dp_sum(dp_sum1),
    .res_valid(valid1), .res_ready(ready1), .res_data(res_data1), .res_idx(res_idx1)
  );

  function automatic logic [VW-1:0] fill(input logic [BW-1:0] v);
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NI; i++) r[i*BW +: BW] = v;
    return r;
  endfunction

  function automatic logic [VW-1:0] garbage();
    logic [VW-1:0] r;
    r = '0;
    for (int i = 0; i < NI; i++) r[i*BW +: BW] = $urandom;
    return r;
  endfunction

  function automatic logic [OW-1:0] dot(input logic [VW-1:0] a, input logic [VW-1:0] w,
                                        input logic [BW-1:0] b);
    logic [OW-1:0] s;
    s = OW'(b);
    for (int i = 0; i < NI; i++) s = s + OW'(a[i*BW +: BW]) * OW'(w[i*BW +: BW]);
    return s;
  endfunction

  // Dot units.
  always_comb dp_sum3 = dot(dp_in3, dp_w3, dp_b3);
  always_comb dp_sum1 = dot(dp_in1, dp_w1, dp_b1);

  // Weight memories: row k holds k+1 everywhere, bias 10*k; garbage otherwise.
  always @(posedge clk) begin
    w_data3 <= w_en3 ? fill(BW'(w_addr3) + 32'd1) : garbage();
    b_data3 <= w_en3 ? BW'(w_addr3) * 32'd10 : $urandom;
    w_data1 <= w_en1 ? fill(BW'(w_addr1) + 32'd1) : garbage();
    b_data1 <= w_en1 ? BW'(w_addr1) * 32'd10 : $urandom;
  end

  exp_t q3[$];
  exp_t q1[$];
  int passed = 0;
  int total = 0;
  int cyc = 0;
  int done3_cnt = 0, done3_cyc = -1;
  int done1_cnt = 0, done1_cyc = -1;
  int fetch1_cnt = 0;
  int bp_left = 0;
  int inj_at = -1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // One clock cycle: drive handshake inputs, score outputs, advance to next negedge.
  task automatic cyc_step();
    exp_t e;
    ready3 = 1'b1;
    ready1 = 1'b1;
    if (inj_at == cyc) begin
      start3  = 1'b1;
      in_vec3 = fill(32'd2);
    end
    if (valid3 === 1'b1 && res_idx3 == AW'(1) && bp_left > 0) begin
      ready3 = 1'b0;
      bp_left--;
      chk("bp_data", res_data3, 250);
      chk("bp_idx", 64'(res_idx3), 1);
      chk("bp_no_fetch", 64'(w_en3), 0);
    end
    if (valid3 === 1'b1 && ready3) begin
      if (q3.size() == 0) chk("res3_unexpected", 64'(valid3), 0);
      else begin
        e = q3.pop_front();
        chk("res3_data", res_data3, e.data);
        chk("res3_idx", 64'(res_idx3), 64'(e.idx));
        chk("res3_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (done3 === 1'b1) begin
      done3_cnt++;
      done3_cyc = cyc;
    end
    if (valid1 === 1'b1 && ready1) begin
      if (q1.size() == 0) chk("res1_unexpected", 64'(valid1), 0);
      else begin
        e = q1.pop_front();
        chk("res1_data", res_data1, e.data);
        chk("res1_idx", 64'(res_idx1), 64'(e.idx));
        chk("res1_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
    if (done1 === 1'b1) begin
      done1_cnt++;
      done1_cyc = cyc;
    end
    if (w_en1 === 1'b1) begin
      fetch1_cnt++;
      chk("w_addr1", 64'(w_addr1), 0);
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
    if (inj_at == cyc - 1) start3 = 1'b0;
  endtask

  task automatic push3(input int t0);
    for (int k = 0; k < 3; k++) q3.push_back('{data: OW'(120 + 130 * k), idx: AW'(k), cyc: t0 + 4 + 4 * k});
  endtask

  task automatic start3_pass(output int t0);
    in_vec3 = fill(32'd1);
    start3  = 1'b1;
    t0      = cyc;
    cyc_step();
    start3  = 1'b0;
    chk("busy_after_start", 64'(busy3), 1);
    chk("fetch_first", 64'(w_en3), 1);
    chk("fetch_addr0", 64'(w_addr3), 0);
  endtask

  task automatic wait_done3(input string tag, input int exp_cyc);
    int d0;
    d0 = done3_cnt;
    for (int n = 0; n < 100 && done3_cnt == d0; n++) cyc_step();
    chk({tag, "_done_cyc"}, 64'(done3_cyc), 64'(exp_cyc));
    for (int n = 0; n < 3; n++) cyc_step();
    chk({tag, "_done_count"}, 64'(done3_cnt - d0), 1);
    chk({tag, "_idle_busy"}, 64'(busy3), 0);
    chk({tag, "_all_results"}, 64'(q3.size()), 0);
  endtask

  task automatic check_zero3(input string tag);
    chk({tag, "_busy"}, 64'(busy3), 0);
    chk({tag, "_done"}, 64'(done3), 0);
    chk({tag, "_w_en"}, 64'(w_en3), 0);
    chk({tag, "_valid"}, 64'(valid3), 0);
    chk({tag, "_w_addr"}, 64'(w_addr3), 0);
    chk({tag, "_res_data"}, res_data3, 0);
    chk({tag, "_res_idx"}, 64'(res_idx3), 0);
    chk({tag, "_dp_in"}, 64'(|dp_in3), 0);
    chk({tag, "_dp_w"}, 64'(|dp_w3), 0);
    chk({tag, "_dp_b"}, 64'(dp_b3), 0);
  endtask

  initial begin
    int t0;
    int d0;
    rst_n   = 1'b0;
    start3  = 1'b0;
    start1  = 1'b0;
    ready3  = 1'b1;
    ready1  = 1'b1;
    in_vec3 = fill(32'd1);
    in_vec1 = fill(32'd1);
    @(negedge clk);
    cyc_step();
    cyc_step();
    rst_n = 1'b1;
    check_zero3("reset");
    chk("reset_busy1", 64'(busy1), 0);
    chk("reset_valid1", 64'(valid1), 0);
    chk("reset_res_idx1", 64'(res_idx1), 0);

    // Normal pass.
    start3_pass(t0);
    push3(t0);
    wait_done3("normal", t0 + 13);
    chk("normal_dp_in_kept", 64'(dp_in3 === fill(32'd1)), 1);

    // Backpressure on neuron 1 for 5 cycles.
    bp_left = 5;
    start3_pass(t0);
    q3.push_back('{data: 64'd120, idx: 7'd0, cyc: t0 + 4});
    q3.push_back('{data: 64'd250, idx: 7'd1, cyc: t0 + 13});
    q3.push_back('{data: 64'd380, idx: 7'd2, cyc: t0 + 17});
    wait_done3("bp", t0 + 18);
    chk("bp_hold_cycles", 64'(bp_left), 0);

    // Start pulse with a different vector while busy.
    start3_pass(t0);
    inj_at = t0 + 6;
    push3(t0);
    wait_done3("busy_start", t0 + 13);
    chk("busy_start_dp_in_kept", 64'(dp_in3 === fill(32'd1)), 1);
    inj_at = -1;

    // Reset during COMPUTE of neuron 1.
    start3_pass(t0);
    q3.push_back('{data: 64'd120, idx: 7'd0, cyc: t0 + 4});
    d0 = done3_cnt;
    for (int n = 0; n < 20 && cyc < t0 + 7; n++) cyc_step();
    rst_n = 1'b0;
    cyc_step();
    rst_n = 1'b1;
    check_zero3("midrst");
    for (int n = 0; n < 4; n++) cyc_step();
    chk("midrst_no_done", 64'(done3_cnt - d0), 0);
    chk("midrst_no_result", 64'(valid3), 0);
    chk("midrst_queue", 64'(q3.size()), 0);
    start3_pass(t0);
    push3(t0);
    wait_done3("after_rst", t0 + 13);

    // Single-neuron instance.
    in_vec1 = fill(32'd1);
    start1  = 1'b1;
    t0      = cyc;
    cyc_step();
    start1  = 1'b0;
    q1.push_back('{data: 64'd120, idx: 7'd0, cyc: t0 + 4});
    d0 = done1_cnt;
    for (int n = 0; n < 50 && done1_cnt == d0; n++) cyc_step();
    for (int n = 0; n < 3; n++) cyc_step();
    chk("n1_done_cyc", 64'(done1_cyc), 64'(t0 + 5));
    chk("n1_done_count", 64'(done1_cnt - d0), 1);
    chk("n1_fetch_count", 64'(fetch1_cnt), 1);
    chk("n1_all_results", 64'(q1.size()), 0);
    chk("n1_idle_busy", 64'(busy1), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fc_layer_seq.md
Name: fc_layer_seq

Overview:
- Sequences one fully-connected layer on the team's shared combinational 120-input dot-product unit. It produces NUM_OUT neurons in turn.
- For each neuron it fetches that neuron's weight row and bias from weight memory and presents the operands to the dot unit. It then registers the sum and hands it downstream over a valid/ready handshake.
- Sits between the layer's input buffer and weight ROM and the next layer's input collector.

Parameters:
- BIT_WIDTH, 32, width of each input, weight and bias element.
- OUT_WIDTH, 64, width of the dot-unit result and of res_data.
- N_IN, 120, elements per row; fixed to match the dot unit.
- NUM_OUT, 84, neurons in the layer (1..2^ADDR_WIDTH).
- ADDR_WIDTH, 7, weight-memory row address width.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  begin a layer pass; sampled only in IDLE.
- in_vec  in  BIT_WIDTH*N_IN  layer input vector; captured on accepted start.
- busy  out  1  high from the cycle after accepted start until DONE is entered.
- done  out  1  one-cycle pulse after the last result is accepted.
- w_rd_en  out  1  weight-memory read strobe.
- w_addr  out  ADDR_WIDTH  row index = neuron index.
- w_rd_data  in  BIT_WIDTH*N_IN  weight row, valid exactly 1 cycle after w_rd_en.
- b_rd_data  in  BIT_WIDTH  bias, same timing as w_rd_data.
- dp_in  out  BIT_WIDTH*N_IN  to dot unit: registered input vector.
- dp_weights  out  BIT_WIDTH*N_IN  to dot unit: registered weight row.
- dp_bias  out  BIT_WIDTH  to dot unit: registered bias.
- dp_sum  in  OUT_WIDTH  from dot unit (combinational).
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts result.
- res_data  out  OUT_WIDTH  registered dp_sum.
- res_idx  out  ADDR_WIDTH  neuron index of res_data.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - State goes to IDLE and the neuron index to 0.
  - busy, done, w_rd_en, res_valid all 0.
  - w_addr, res_data, res_idx, dp_in, dp_weights, dp_bias all 0.
  - Reset mid-pass aborts the pass silently. A pending result is dropped and done is not pulsed.
- FSM states: IDLE, FETCH, WAIT, COMPUTE, OUTPUT, DONE.
- IDLE:
  - If start=1: latch in_vec into the dp_in register, set idx=0, go to FETCH.
  - Otherwise stay in IDLE.
- FETCH: w_rd_en=1, w_addr=idx for exactly this cycle; go to WAIT.
- WAIT: at the end of the cycle, capture w_rd_data into dp_weights and b_rd_data into dp_bias; go to COMPUTE.
- COMPUTE: operands are stable for the whole cycle. At the end, capture dp_sum into res_data and idx into res_idx; go to OUTPUT.
- OUTPUT:
  - res_valid=1. res_data and res_idx hold constant until res_valid&&res_ready.
  - On acceptance with idx==NUM_OUT-1: go to DONE.
  - On acceptance otherwise: idx+1, go to FETCH.
  - res_valid drops in the cycle after acceptance.
- DONE: done=1 and busy=0 for one cycle; go to IDLE.
- busy is 1 in FETCH, WAIT, COMPUTE and OUTPUT, and 0 in IDLE and DONE.
- start while busy or in DONE is ignored; it is not queued.
- Latency:
  - start at cycle 0 gives FETCH at 1, WAIT at 2, COMPUTE at 3, first res_valid at 4.
  - With res_ready held at 1, each neuron takes 4 cycles. The last res_valid is at cycle 4*NUM_OUT and done at 4*NUM_OUT+1.
- Arithmetic:
  - The block performs no arithmetic on data.
  - res_data is dp_sum bit-for-bit; wrap behaviour is inherited from the dot unit.
  - The index counter never exceeds NUM_OUT-1.
- dp_in stays constant for the whole pass. A new in_vec is taken only on the next accepted start.
- NUM_OUT=1: a single FETCH..OUTPUT iteration, then DONE.

Test Plan:
- Normal pass, NUM_OUT=3, with the dot unit instantiated:
  - Stimulus: all in_vec elements 1, row k weights all k+1, bias 10*k, res_ready=1.
  - Response: results 120/250/380 with res_idx 0/1/2 at cycles 4/8/12, and done at cycle 13.
- Backpressure:
  - Stimulus: hold res_ready=0 for 5 cycles on neuron 1.
  - Response: res_valid stays 1 and res_data=250, res_idx=1 stay stable. There is no FETCH of row 2 until acceptance, and done is delayed by 5 cycles.
- Start while busy:
  - Stimulus: pulse start at cycle 6 with a different in_vec.
  - Response: no effect. Results are identical to the normal pass and there is exactly one done pulse.
- Reset mid-pass:
  - Stimulus: rst_n=0 for 1 cycle during COMPUTE of neuron 1.
  - Response: next cycle all outputs are 0, state is IDLE and there is no done. A fresh start then reproduces 120/250/380 from idx 0.
- Boundary, NUM_OUT=1:
  - Stimulus: a single start.
  - Response: one result at cycle 4 and done at cycle 5. w_rd_en is asserted exactly once, with w_addr=0.
- Memory timing check:
  - Stimulus: bench memory drives garbage on w_rd_data except in the cycle after w_rd_en.
  - Response: results are still correct, proving capture happens only in WAIT.
